// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RV32 load/store unit: funct3 codes, opcodes,
// FSM state encoding and the illegal-funct3 decode.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } lsu_state_e;

  // Stores only have SB/SH/SW; loads additionally lack 3, 6 and 7.
  function automatic logic f3_illegal(input logic wen, input logic [2:0] f3);
    if (wen) return (f3 >= 3'd3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension,
// sub-word store merge into a read word, and alignment check.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_store,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_W:    o_load = i_rdata;
      F3_BU:   o_load = {24'd0, w_byte};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = '0;
    endcase
  end

  // Only the addressed lane is replaced; the rest of the read word is kept.
  always_comb begin
    o_store = i_rdata;
    case (i_funct3[1:0])
      2'b00: o_store[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
      2'b01: begin
        if (i_addr[1]) o_store[31:16] = i_wdata[15:0];
        else           o_store[15:0]  = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

  assign o_misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (i_addr != 2'b00));

endmodule

// File: rtl/riscv_lsu.sv
// RV32 load/store unit: one request at a time, word accesses to data memory,
// read-modify-write for SB/SH, all memory and response outputs registered.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_e            r_state;
  logic                  r_wen;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_mem_wen;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  logic [2:0]            w_al_funct3;
  logic [1:0]            w_al_addr;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_store;
  logic                  w_misalign;
  logic                  w_err;
  logic                  w_unused_addr;

  // In IDLE the lane logic checks the incoming request; afterwards it works
  // on the latched fields and the word returned by memory.
  assign w_al_funct3   = (r_state == S_IDLE) ? req_funct3   : r_funct3;
  assign w_al_addr     = (r_state == S_IDLE) ? req_addr[1:0] : r_addr_lo;
  assign w_err         = f3_illegal(req_wen, req_funct3) | w_misalign;
  assign w_unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  riscv_lsu_align u_align (
    .i_funct3   (w_al_funct3),
    .i_addr     (w_al_addr),
    .i_rdata    (mem_rdata),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_store    (w_store),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wen       <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_wdata     <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_wen     <= req_wen;
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_wdata   <= req_wdata;
            if (w_err) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (!req_wen || (req_funct3 != F3_W)) begin
              r_state    <= S_RD;
              r_mem_addr <= req_addr[ADDR_WIDTH+1:2];
            end else begin
              r_state     <= S_WR;
              r_mem_addr  <= req_addr[ADDR_WIDTH+1:2];
              r_mem_wen   <= 1'b1;
              r_mem_wdata <= req_wdata;
            end
          end
        end
        S_RD: begin
          if (!r_wen) begin
            r_state     <= S_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_load;
          end else begin
            r_state     <= S_WR;
            r_mem_wen   <= 1'b1;
            r_mem_wdata <= w_store;
          end
        end
        S_WR: begin
          r_state     <= S_RSP;
          r_mem_wen   <= 1'b0;
          r_mem_wdata <= '0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        S_RSP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) & ~reset;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_riscv_lsu.sv
// Scoreboard bench for riscv_lsu: directed requests push expected responses,
// a monitor pops them on rsp_valid and checks data, error flag and latency.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wen;
  logic [14:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:32767];

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int rsp_count = 0;
  int wr_count = 0;
  int wdata_leak = 0;
  logic [14:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  riscv_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else
      passes++;
  endfunction

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    mem[4] = 32'h1122_3344;
    forever begin
      @(posedge clk);
      if (mem_wen) mem[mem_addr] <= mem_wdata;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write tracker and response scoreboard, both sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (mem_wen) begin
      wr_count++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end else if (mem_wdata != 32'd0) begin
      wdata_leak++;
    end
    if (!reset && rsp_valid) begin
      rsp_count++;
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        chk({e.name, "_latency"}, cyc - a, e.lat);
        chk({e.name, "_ready_in_rsp"}, {31'd0, req_ready}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic do_req(input string name, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input bit expect_rsp, input bit hold);
    int guard = 0;
    if (expect_rsp) exp_q.push_back('{name, exp_rdata, exp_err, exp_lat});
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk({name, "_accept_timeout"}, 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (expect_rsp) acc_q.push_back(cyc);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
    chk({name, "_ready_after_accept"}, {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  int wr0;
  int rc0;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,          32'd0);
    chk("rst_mem_wen",   {31'd0, mem_wen},   32'd0);
    chk("rst_mem_addr",  {17'd0, mem_addr},  32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // SB aborted by reset while in RD.
    wr0 = wr_count;
    rc0 = rsp_count;
    do_req("sb_abort", 1'b1, 3'd0, 32'h13, 32'h55, 32'd0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_in_rst", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_no_write", wr_count - wr0, 32'd0);
    chk("abort_no_rsp", rsp_count - rc0, 32'd0);
    chk("abort_mem4", mem[4], 32'h1122_3344);

    // SW: single write cycle, no read cycle.
    wr0 = wr_count;
    do_req("sw", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    chk("sw_write_cycles", wr_count - wr0, 32'd1);
    chk("sw_wr_addr", {17'd0, last_wr_addr}, 32'd4);
    chk("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
    chk("sw_mem4", mem[4], 32'hDEAD_BEEF);

    do_req("sw2", 1'b1, 3'd2, 32'h10, 32'h1122_3344, 32'd0, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();

    // SB by read-modify-write.
    wr0 = wr_count;
    do_req("sb", 1'b1, 3'd0, 32'h13, 32'h0000_00AA, 32'd0, 1'b0, 3, 1'b1, 1'b0);
    wait_drain();
    chk("sb_write_cycles", wr_count - wr0, 32'd1);
    chk("sb_wr_data", last_wr_data, 32'hAA22_3344);
    chk("sb_mem4", mem[4], 32'hAA22_3344);

    // Loads from 0xAA223344.
    do_req("lb",  1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFF_FFAA, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    do_req("lbu", 1'b0, 3'd4, 32'h13, 32'd0, 32'h0000_00AA, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    do_req("lh",  1'b0, 3'd1, 32'h12, 32'd0, 32'hFFFF_AA22, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    do_req("lhu", 1'b0, 3'd5, 32'h10, 32'd0, 32'h0000_3344, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    do_req("lw",  1'b0, 3'd2, 32'h10, 32'd0, 32'hAA22_3344, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    do_req("lw_wrap", 1'b0, 3'd2, 32'h0002_0010, 32'd0, 32'hAA22_3344, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();

    // Misaligned and illegal requests never touch memory.
    wr0 = wr_count;
    do_req("lw_mis", 1'b0, 3'd2, 32'h11, 32'd0, 32'd0, 1'b1, 1, 1'b1, 1'b0);
    wait_drain();
    do_req("sh_mis", 1'b1, 3'd1, 32'h13, 32'h1234, 32'd0, 1'b1, 1, 1'b1, 1'b0);
    wait_drain();
    do_req("ld_f3_3", 1'b0, 3'd3, 32'h10, 32'd0, 32'd0, 1'b1, 1, 1'b1, 1'b0);
    wait_drain();
    do_req("ld_f3_6", 1'b0, 3'd6, 32'h10, 32'd0, 32'd0, 1'b1, 1, 1'b1, 1'b0);
    wait_drain();
    do_req("st_f3_4", 1'b1, 3'd4, 32'h10, 32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1'b1, 1'b0);
    wait_drain();
    chk("err_no_write", wr_count - wr0, 32'd0);
    chk("err_mem4", mem[4], 32'hAA22_3344);

    // SH into the upper half, then read it back signed.
    do_req("sh", 1'b1, 3'd1, 32'h12, 32'hFFFF_5566, 32'd0, 1'b0, 3, 1'b1, 1'b0);
    wait_drain();
    chk("sh_mem4", mem[4], 32'h5566_3344);
    do_req("lh_pos", 1'b0, 3'd1, 32'h12, 32'd0, 32'h0000_5566, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();

    // Three loads with req_valid held high throughout.
    rc0 = rsp_count;
    do_req("b2b_lw",  1'b0, 3'd2, 32'h10, 32'd0, 32'h5566_3344, 1'b0, 2, 1'b1, 1'b1);
    do_req("b2b_lbu", 1'b0, 3'd4, 32'h10, 32'd0, 32'h0000_0044, 1'b0, 2, 1'b1, 1'b1);
    do_req("b2b_lb",  1'b0, 3'd0, 32'h11, 32'd0, 32'h0000_0033, 1'b0, 2, 1'b1, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("b2b_rsp_count", rsp_count - rc0, 32'd3);

    chk("mem_wdata_zero_when_idle", wdata_leak, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
